// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin access controller that lets several cores
// share one single-port data RAM with a one-cycle registered read.
// Optional feature: define DATA_MEM_ARBITER_BOUNDS_EN to enable out-of-range
// address checking (suppressed writes, zeroed read data, err pulse).
module data_mem_arbiter #(
    parameter int CORES      = 4,
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CORES-1:0]            req,
    input  logic [CORES-1:0]            wr,
    input  logic [CORES*ADDR_WIDTH-1:0] addr,
    input  logic [CORES*WIDTH-1:0]      wdata,
    output logic [CORES-1:0]            ack,
    output logic [WIDTH-1:0]            rdata,
    output logic                        err,
    output logic                        busy,
    output logic                        mem_wrEn,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]            mem_dataIn,
    input  logic [WIDTH-1:0]            mem_dataOut
);

    localparam int PW = $clog2(CORES);

    // The address bus must be able to reach every valid word.
    if (ADDR_WIDTH < $clog2(DEPTH)) begin : gBadAddrWidth
        $error("ADDR_WIDTH too small for DEPTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        READ,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PW-1:0]          grant_q, grant_d;
    logic                   isWrite_q, isWrite_d;
    logic                   memWrEn_q, memWrEn_d;
    logic [ADDR_WIDTH-1:0]  memAddr_q, memAddr_d;
    logic [WIDTH-1:0]       memDataIn_q, memDataIn_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;

    logic                   found;
    logic [PW-1:0]          pick;
    logic [ADDR_WIDTH-1:0]  selAddr;
    logic [WIDTH-1:0]       selData;
    logic                   selWr;

`ifdef DATA_MEM_ARBITER_BOUNDS_EN
    logic                   oob_q, oob_d;
    logic                   outOfRange;
`endif

    // Round-robin search starting just after the last granted core; also muxes out the winner's inputs.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        pick    = '0;
        selAddr = '0;
        selData = '0;
        selWr   = 1'b0;
        for (int k = 1; k <= CORES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= CORES) begin
                idx = idx - CORES;
            end
            if (!found && req[idx]) begin
                found   = 1'b1;
                pick    = PW'(idx);
                selAddr = addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                selData = wdata[idx*WIDTH +: WIDTH];
                selWr   = wr[idx];
            end
        end
    end

`ifdef DATA_MEM_ARBITER_BOUNDS_EN
    // Flag a granted address that falls beyond the populated part of the RAM.
    always_comb begin
        outOfRange = (32'(selAddr) >= 32'(DEPTH));
    end
`endif

    // Next-state logic: IDLE latches the winner, ACCESS lets the RAM sample, READ captures data, DONE acknowledges.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        isWrite_d   = isWrite_q;
        memWrEn_d   = memWrEn_q;
        memAddr_d   = memAddr_q;
        memDataIn_d = memDataIn_q;
        rdata_d     = rdata_q;
`ifdef DATA_MEM_ARBITER_BOUNDS_EN
        oob_d       = oob_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d     = pick;
                    ptr_d       = pick;
                    memAddr_d   = selAddr;
                    memDataIn_d = selData;
                    isWrite_d   = selWr;
                    memWrEn_d   = selWr;
`ifdef DATA_MEM_ARBITER_BOUNDS_EN
                    oob_d       = outOfRange;
                    if (outOfRange) begin
                        memWrEn_d = 1'b0;
                    end
`endif
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                memWrEn_d = 1'b0;
                state_d   = isWrite_q ? DONE : READ;
            end
            READ: begin
`ifdef DATA_MEM_ARBITER_BOUNDS_EN
                rdata_d = oob_q ? '0 : mem_dataOut;
`else
                rdata_d = mem_dataOut;
`endif
                state_d = DONE;
            end
            DONE: begin
                memAddr_d   = '0;
                memDataIn_d = '0;
`ifdef DATA_MEM_ARBITER_BOUNDS_EN
                oob_d       = 1'b0;
`endif
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset abandons any transaction without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(CORES - 1);
            grant_q     <= '0;
            isWrite_q   <= 1'b0;
            memWrEn_q   <= 1'b0;
            memAddr_q   <= '0;
            memDataIn_q <= '0;
            rdata_q     <= '0;
`ifdef DATA_MEM_ARBITER_BOUNDS_EN
            oob_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            isWrite_q   <= isWrite_d;
            memWrEn_q   <= memWrEn_d;
            memAddr_q   <= memAddr_d;
            memDataIn_q <= memDataIn_d;
            rdata_q     <= rdata_d;
`ifdef DATA_MEM_ARBITER_BOUNDS_EN
            oob_q       <= oob_d;
`endif
        end
    end

    // Status outputs decoded from the registered state; ack is a one-hot pulse to the granted core.
    always_comb begin
        ack  = (state_q == DONE) ? (CORES'(1) << grant_q) : '0;
        busy = (state_q != IDLE);
`ifdef DATA_MEM_ARBITER_BOUNDS_EN
        err  = (state_q == DONE) && oob_q;
`else
        err  = 1'b0;
`endif
    end

    assign rdata      = rdata_q;
    assign mem_wrEn   = memWrEn_q;
    assign mem_addr   = memAddr_q;
    assign mem_dataIn = memDataIn_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Multi-core access controller for the shared data RAM. It arbitrates read/write requests from up to `CORES` processing cores with round-robin priority and drives the RAM port. The RAM writes in one cycle and registers its read address, so read data is valid the cycle after the address is sampled. The block sits between the cores' memory stages and the single-port data RAM, and returns one acknowledge per completed access.

## Interface
- `CORES`, 4: number of requesting cores (2–8).
- `WIDTH`, 12: data word width.
- `DEPTH`, 4096: number of valid RAM words.
- `ADDR_WIDTH`, 12: address width, at least $clog2(DEPTH).

- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, CORES: per-core request, held until that core's `ack`.
- `wr`, in, CORES: per-core 1 = write, 0 = read; stable while `req` is high.
- `addr`, in, CORES*ADDR_WIDTH: packed addresses, core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `wdata`, in, CORES*WIDTH: packed write data, same packing.
- `ack`, out, CORES: one-cycle completion pulse to the granted core.
- `rdata`, out, WIDTH: read data, shared by all cores, valid when `ack` pulses for a read.
- `err`, out, 1: out-of-range flag, pulses with `ack` (see Configuration).
- `busy`, out, 1: high in any state other than IDLE.
- `mem_wrEn`, out, 1: RAM write enable.
- `mem_addr`, out, ADDR_WIDTH: RAM address.
- `mem_dataIn`, out, WIDTH: RAM write data.
- `mem_dataOut`, in, WIDTH: RAM read data. It is valid in the cycle after `mem_addr` was sampled.

## Operation
- The FSM has the states IDLE, ACCESS, READ and DONE.
- **IDLE:** if any `req` bit is high, grant index g is the first requesting core found searching cyclically from `ptr+1`.
  - Register `mem_addr`, `mem_dataIn` and `mem_wrEn` (= `wr[g]`) from core g's inputs.
  - Set `ptr <= g` and go to ACCESS.
- **ACCESS:** the RAM port values are stable and the RAM samples them at the end of this cycle.
  - Next state is DONE for a write and READ for a read.
  - `mem_wrEn` is cleared on leaving ACCESS, so it is high for exactly one cycle per write.
- **READ:** `mem_dataOut` is valid; capture it into `rdata`, then go to DONE.
- **DONE:** `ack[g]` = 1 for this single cycle, then go to IDLE.
- `rdata` holds its value until the next read capture.
- **Request rules:**
  - A core deasserts `req` in the cycle after its `ack`.
  - `req` dropped mid-transaction does not abort the access; it completes and acks.
  - `wr`, `addr` and `wdata` are sampled only in IDLE, so later changes are ignored.
- **Outputs while not granted:** `mem_addr`, `mem_dataIn` and `ack` are 0 in IDLE.
- **Round-robin:** `ptr` resets to CORES-1, so core 0 wins the first contention. A core that is continuously requesting waits at most CORES-1 other grants.

## Timing
- Request first sampled high at edge E0 (the cycle ending E0 is cycle 0):
  - Write: ACCESS in cycle 1 (RAM written at E1 + 1 edge), `ack` in cycle 2.
  - Read: ACCESS in cycle 1, READ in cycle 2, `ack` and valid `rdata` in cycle 3.
- Throughput: one write per 3 cycles, one read per 4 cycles (DONE→IDLE costs one cycle).
- **Reset values:** `ack`=0, `err`=0, `busy`=0, `rdata`=0, `mem_wrEn`=0, `mem_addr`=0, `mem_dataIn`=0; state IDLE, `ptr`=CORES-1.
- **Reset mid-operation:**
  - Any state returns to IDLE with no `ack` issued.
  - A write already sampled by the RAM stays in memory.
  - If `rst` is high during ACCESS, `mem_wrEn` is low on the next cycle.

## Configuration
- `DATA_MEM_ARBITER_BOUNDS_EN` defined:
  - In IDLE, a granted address ≥ DEPTH forces `mem_wrEn`=0.
  - For a read, `rdata` is loaded with 0 in READ.
  - `err` pulses with `ack` in DONE.
  - The transaction latency is unchanged.
- Not defined: addresses pass through unchecked, `err` is tied to 0, and there is no compare logic.

## Test plan
- **Reset:** assert `rst` 2 cycles with random `req` → all outputs at reset values; first contention among all cores grants core 0.
- **Write then read:** core 1 writes 12'hABC at addr 12'h010 → `mem_wrEn` high exactly one cycle (cycle 1, `mem_addr`=12'h010, `mem_dataIn`=12'hABC) and `ack[1]` in cycle 2. Core 1 then reads 12'h010 → `ack[1]` in cycle 3 with `rdata`=12'hABC.
- **Four-way contention:** all 4 cores read distinct preloaded addresses simultaneously → acks in order 0,1,2,3, each exactly once, each `rdata` matching its address's preloaded content.
- **Fairness:** cores 0 and 2 re-request immediately after each ack for 8 transactions → grant sequence 0,2,0,2,…; core 2 never waits more than one grant.
- **Reset in READ:** assert `rst` in READ state → no `ack`, `busy`=0 next cycle, `rdata`=0. A retried read then completes normally.
- **Bounds** (macro defined, DEPTH=3000):
  - Write addr 3000 → `mem_wrEn` never high, `ack` and `err` together in cycle 2.
  - Read addr 3000 → `rdata`=0 and `err`=1 in cycle 3.
  - Addr 2999 → `err`=0.
